// File: rtl/smi_transaction_throttle_if.sv
// SMI request/response link bundle seen by one transaction throttle.
// "slave" is the throttle's view and "master" is the surrounding client/arbiter view.
interface smi_transaction_throttle_if #(
  parameter int DataWidth = 32
);
  logic                 smiReqInReady;
  logic [7:0]           smiReqInEofc;
  logic [DataWidth-1:0] smiReqInData;
  logic                 smiReqInStop;

  logic                 smiReqOutReady;
  logic [7:0]           smiReqOutEofc;
  logic [DataWidth-1:0] smiReqOutData;
  logic                 smiReqOutStop;

  logic                 smiRespInReady;
  logic [7:0]           smiRespInEofc;
  logic [DataWidth-1:0] smiRespInData;
  logic                 smiRespInStop;

  logic                 smiRespOutReady;
  logic [7:0]           smiRespOutEofc;
  logic [DataWidth-1:0] smiRespOutData;
  logic                 smiRespOutStop;

  modport slave (
    input  smiReqInReady, smiReqInEofc, smiReqInData,
    output smiReqInStop,
    output smiReqOutReady, smiReqOutEofc, smiReqOutData,
    input  smiReqOutStop,
    input  smiRespInReady, smiRespInEofc, smiRespInData,
    output smiRespInStop,
    output smiRespOutReady, smiRespOutEofc, smiRespOutData,
    input  smiRespOutStop
  );

  modport master (
    output smiReqInReady, smiReqInEofc, smiReqInData,
    input  smiReqInStop,
    input  smiReqOutReady, smiReqOutEofc, smiReqOutData,
    output smiReqOutStop,
    output smiRespInReady, smiRespInEofc, smiRespInData,
    input  smiRespInStop,
    input  smiRespOutReady, smiRespOutEofc, smiRespOutData,
    output smiRespOutStop
  );
endinterface

// File: rtl/smi_transaction_throttle.sv
// Per-port outstanding-transaction limiter placed in front of one SMI arbiter port.
// It holds off new request frames while MaxOutstanding transactions are unanswered.
// Frames already in progress are never stalled by the limit.
module smi_transaction_throttle #(
  parameter int FlitWidth      = 4,
  parameter int MaxOutstanding = 4,
  parameter int DataWidth      = FlitWidth * 8
) (
  input  logic                         clk,
  input  logic                         srst,
  smi_transaction_throttle_if.slave    smi,
  output logic [7:0]                   outstanding,
  output logic                         throttled,
  output logic                         underflowErr
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  localparam logic [7:0] MAX_COUNT = 8'(MaxOutstanding);

  logic [0:0]           state;
  logic [7:0]           count;
  logic                 underflow;
  logic                 in_frame;
  logic                 gate;
  logic                 req_xfer;
  logic                 resp_xfer;
  logic                 inc;
  logic                 dec;
  logic [DataWidth-1:0] req_data;
  logic [DataWidth-1:0] resp_data;

  assign in_frame = (state == BUSY);

  // The gate looks only at the registered count, so a response finishing this cycle frees a slot next cycle.
  assign gate = in_frame | (count < MAX_COUNT);

  // Request handshake: the gate only matters at a frame start, and reset forces the link idle.
  assign smi.smiReqOutReady = ~srst & smi.smiReqInReady & gate;
  assign smi.smiReqInStop   = srst | smi.smiReqOutStop | ~gate;
  assign throttled          = ~srst & smi.smiReqInReady & ~gate;

  // Response handshake is a plain passthrough except while in reset.
  assign smi.smiRespOutReady = ~srst & smi.smiRespInReady;
  assign smi.smiRespInStop   = srst | smi.smiRespOutStop;

  // Flit payloads pass through with zero latency.
  assign req_data            = smi.smiReqInData;
  assign resp_data           = smi.smiRespInData;
  assign smi.smiReqOutData   = req_data;
  assign smi.smiRespOutData  = resp_data;
  assign smi.smiReqOutEofc   = smi.smiReqInEofc;
  assign smi.smiRespOutEofc  = smi.smiRespInEofc;

  // A flit moves when the link shows valid without stop.
  assign req_xfer  = smi.smiReqInReady & ~smi.smiReqInStop;
  assign resp_xfer = smi.smiRespInReady & ~smi.smiRespInStop;
  assign inc       = req_xfer & ~in_frame;
  assign dec       = resp_xfer & (smi.smiRespInEofc != 8'd0);

  // Track whether the request side is inside a multi-flit frame.
  always_ff @(posedge clk) begin
    if (srst) begin
      state <= IDLE;
    end else if (req_xfer) begin
      if (smi.smiReqInEofc != 8'd0) begin
        state <= IDLE;
      end else begin
        state <= BUSY;
      end
    end
  end

  // In-flight counter and sticky underflow flag.
  always_ff @(posedge clk) begin
    if (srst) begin
      count     <= 8'd0;
      underflow <= 1'b0;
    end else if (inc && !dec) begin
      count <= count + 8'd1;
    end else if (dec && !inc) begin
      if (count != 8'd0) begin
        count <= count - 8'd1;
      end else begin
        underflow <= 1'b1;
      end
    end
  end

  assign outstanding  = count;
  assign underflowErr = underflow;

endmodule

// File: tb/tb_smi_transaction_throttle.sv
// Scoreboard bench for smi_transaction_throttle with MaxOutstanding=2.
// Directed cycles push predicted flits, and a negedge monitor checks every flit the DUT passes on.
module tb_smi_transaction_throttle;

  logic clk;
  logic srst;
  logic [7:0] outstanding;
  logic throttled;
  logic underflow_err;

  int tests_run;
  int tests_failed;

  logic [39:0] req_q[$];
  logic [39:0] resp_q[$];

  smi_transaction_throttle_if #(.DataWidth(32)) smi ();

  smi_transaction_throttle #(
    .FlitWidth(4),
    .MaxOutstanding(2)
  ) dut (
    .clk(clk),
    .srst(srst),
    .smi(smi),
    .outstanding(outstanding),
    .throttled(throttled),
    .underflowErr(underflow_err)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs and queue the flits that should move this cycle.
  task automatic applyStimulus(
    input logic req_v, input logic [7:0] req_e, input logic [31:0] req_d, input logic req_exp,
    input logic resp_v, input logic [7:0] resp_e, input logic [31:0] resp_d, input logic resp_exp);
    smi.smiReqInReady  = req_v;
    smi.smiReqInEofc   = req_e;
    smi.smiReqInData   = req_d;
    smi.smiRespInReady = resp_v;
    smi.smiRespInEofc  = resp_e;
    smi.smiRespInData  = resp_d;
    if (req_exp)  req_q.push_back({req_e, req_d});
    if (resp_exp) resp_q.push_back({resp_e, resp_d});
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every flit leaving the DUT must match the head of its expectation queue.
  always @(negedge clk) begin
    if (smi.smiReqOutReady && !smi.smiReqOutStop) begin
      if (req_q.size() == 0) begin
        checkOutput("unexpected_req_flit", {24'd0, smi.smiReqOutEofc, smi.smiReqOutData}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        checkOutput("req_flit", {24'd0, smi.smiReqOutEofc, smi.smiReqOutData}, {24'd0, req_q.pop_front()});
      end
    end
    if (smi.smiRespOutReady && !smi.smiRespOutStop) begin
      if (resp_q.size() == 0) begin
        checkOutput("unexpected_resp_flit", {24'd0, smi.smiRespOutEofc, smi.smiRespOutData}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        checkOutput("resp_flit", {24'd0, smi.smiRespOutEofc, smi.smiRespOutData}, {24'd0, resp_q.pop_front()});
      end
    end
  end

  // Directed sequence.
  initial begin
    tests_run = 0;
    tests_failed = 0;
    srst = 1'b1;
    smi.smiReqOutStop  = 1'b0;
    smi.smiRespOutStop = 1'b0;
    applyStimulus(1'b0, 8'd0, 32'd0, 1'b0, 1'b0, 8'd0, 32'd0, 1'b0);
    step();
    step();
    srst = 1'b0;
    #1;
    checkOutput("reset_outstanding", {56'd0, outstanding}, 64'd0);
    checkOutput("reset_underflow", {63'd0, underflow_err}, 64'd0);

    // Fill to the limit with single-flit frames.
    applyStimulus(1'b1, 8'd4, 32'hA000_0001, 1'b1, 1'b0, 8'd0, 32'd0, 1'b0);
    checkOutput("first_not_throttled", {63'd0, throttled}, 64'd0);
    step();
    checkOutput("count_after_1", {56'd0, outstanding}, 64'd1);
    applyStimulus(1'b1, 8'd4, 32'hA000_0002, 1'b1, 1'b0, 8'd0, 32'd0, 1'b0);
    step();
    checkOutput("count_after_2", {56'd0, outstanding}, 64'd2);
    applyStimulus(1'b1, 8'd4, 32'hA000_0003, 1'b0, 1'b0, 8'd0, 32'd0, 1'b0);
    checkOutput("third_stop", {63'd0, smi.smiReqInStop}, 64'd1);
    checkOutput("third_throttled", {63'd0, throttled}, 64'd1);
    checkOutput("third_out_ready", {63'd0, smi.smiReqOutReady}, 64'd0);
    step();
    checkOutput("count_held_2", {56'd0, outstanding}, 64'd2);

    // Release: the response frees a slot only from the next cycle.
    applyStimulus(1'b1, 8'd4, 32'hA000_0003, 1'b0, 1'b1, 8'd4, 32'hB000_0001, 1'b1);
    checkOutput("still_stopped_same_cycle", {63'd0, smi.smiReqInStop}, 64'd1);
    step();
    checkOutput("count_after_release", {56'd0, outstanding}, 64'd1);
    applyStimulus(1'b1, 8'd4, 32'hA000_0003, 1'b1, 1'b0, 8'd0, 32'd0, 1'b0);
    checkOutput("held_now_passes", {63'd0, throttled}, 64'd0);
    step();
    checkOutput("count_back_2", {56'd0, outstanding}, 64'd2);
    applyStimulus(1'b0, 8'd0, 32'd0, 1'b0, 1'b1, 8'd4, 32'hB000_0002, 1'b1);
    step();
    checkOutput("count_drain_1", {56'd0, outstanding}, 64'd1);

    // Multi-flit frame that reaches the limit after its first flit must not stall.
    applyStimulus(1'b1, 8'd0, 32'hC000_0001, 1'b1, 1'b1, 8'd0, 32'hD000_0001, 1'b1);
    step();
    checkOutput("mid_count_2", {56'd0, outstanding}, 64'd2);
    applyStimulus(1'b1, 8'd0, 32'hC000_0002, 1'b1, 1'b1, 8'd0, 32'hD000_0002, 1'b1);
    checkOutput("mid_flit2_stop", {63'd0, smi.smiReqInStop}, 64'd0);
    checkOutput("mid_flit2_throttled", {63'd0, throttled}, 64'd0);
    step();
    applyStimulus(1'b1, 8'd4, 32'hC000_0003, 1'b1, 1'b1, 8'd4, 32'hD000_0003, 1'b1);
    checkOutput("mid_flit3_stop", {63'd0, smi.smiReqInStop}, 64'd0);
    step();
    checkOutput("mid_end_count_1", {56'd0, outstanding}, 64'd1);

    // Frame start and response completion in the same cycle cancel.
    applyStimulus(1'b1, 8'd4, 32'hE000_0001, 1'b1, 1'b1, 8'd8, 32'hF000_0001, 1'b1);
    step();
    checkOutput("simultaneous_count", {56'd0, outstanding}, 64'd1);
    applyStimulus(1'b0, 8'd0, 32'd0, 1'b0, 1'b1, 8'd4, 32'hF000_0002, 1'b1);
    step();
    checkOutput("drain_count_0", {56'd0, outstanding}, 64'd0);

    // Arbiter and client backpressure block transfers without counting.
    smi.smiReqOutStop  = 1'b1;
    smi.smiRespOutStop = 1'b1;
    applyStimulus(1'b1, 8'd4, 32'h1111_0001, 1'b0, 1'b1, 8'd4, 32'h2222_0001, 1'b0);
    checkOutput("arb_stop_passthrough", {63'd0, smi.smiReqInStop}, 64'd1);
    checkOutput("arb_stop_not_throttled", {63'd0, throttled}, 64'd0);
    checkOutput("resp_stop_passthrough", {63'd0, smi.smiRespInStop}, 64'd1);
    step();
    checkOutput("backpressure_count_0", {56'd0, outstanding}, 64'd0);
    checkOutput("backpressure_no_underflow", {63'd0, underflow_err}, 64'd0);
    smi.smiReqOutStop  = 1'b0;
    smi.smiRespOutStop = 1'b0;

    // Underflow: a stray response still passes and sets the sticky flag.
    applyStimulus(1'b0, 8'd0, 32'd0, 1'b0, 1'b1, 8'd2, 32'h3333_0001, 1'b1);
    step();
    checkOutput("underflow_set", {63'd0, underflow_err}, 64'd1);
    checkOutput("underflow_count_0", {56'd0, outstanding}, 64'd0);
    applyStimulus(1'b0, 8'd0, 32'd0, 1'b0, 1'b0, 8'd0, 32'd0, 1'b0);
    step();
    checkOutput("underflow_sticky", {63'd0, underflow_err}, 64'd1);
    srst = 1'b1;
    step();
    srst = 1'b0;
    #1;
    checkOutput("underflow_cleared", {63'd0, underflow_err}, 64'd0);

    // Reset in the middle of a frame abandons it.
    applyStimulus(1'b1, 8'd0, 32'h4444_0001, 1'b1, 1'b0, 8'd0, 32'd0, 1'b0);
    step();
    checkOutput("rst_mid_count_1", {56'd0, outstanding}, 64'd1);
    srst = 1'b1;
    applyStimulus(1'b1, 8'd0, 32'h4444_0002, 1'b0, 1'b1, 8'd4, 32'h5555_0001, 1'b0);
    checkOutput("rst_req_out_ready", {63'd0, smi.smiReqOutReady}, 64'd0);
    checkOutput("rst_resp_out_ready", {63'd0, smi.smiRespOutReady}, 64'd0);
    checkOutput("rst_req_in_stop", {63'd0, smi.smiReqInStop}, 64'd1);
    checkOutput("rst_resp_in_stop", {63'd0, smi.smiRespInStop}, 64'd1);
    step();
    srst = 1'b0;
    applyStimulus(1'b0, 8'd0, 32'd0, 1'b0, 1'b0, 8'd0, 32'd0, 1'b0);
    checkOutput("post_rst_count_0", {56'd0, outstanding}, 64'd0);
    // A single flit after reset is a new frame start, so it must count.
    applyStimulus(1'b1, 8'd4, 32'h4444_0003, 1'b1, 1'b0, 8'd0, 32'd0, 1'b0);
    step();
    checkOutput("post_rst_frame_start", {56'd0, outstanding}, 64'd1);
    applyStimulus(1'b0, 8'd0, 32'd0, 1'b0, 1'b1, 8'd4, 32'h5555_0002, 1'b1);
    step();
    checkOutput("final_count_0", {56'd0, outstanding}, 64'd0);
    applyStimulus(1'b0, 8'd0, 32'd0, 1'b0, 1'b0, 8'd0, 32'd0, 1'b0);
    step();

    checkOutput("req_queue_drained", 64'(req_q.size()), 64'd0);
    checkOutput("resp_queue_drained", 64'(resp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
